// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and transaction sequencer for the snooping coherence bus.
// Latency: grant 1 cycle after request in IDLE; bus_start is combinational in GRANT.
// Backpressure: holds GRANT until bus_ready; optional watchdog (BUS_ARBITER_WATCHDOG_EN).
module bus_arbiter #(
    parameter int NUM_CPUS         = 4,
    parameter int BLOCK_SIZE_WORDS = 2,
    parameter int WATCHDOG_CYCLES  = 25,
    localparam int ID_W = $clog2(NUM_CPUS),
    localparam int BW   = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_CPUS-1:0] req,
    output logic [NUM_CPUS-1:0] grant,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    input  logic                bus_ready,
    output logic                bus_start,
    input  logic                beat_valid,
    output logic [BW-1:0]       beat_idx,
    input  logic                bus_done,
    output logic                timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_CPUS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     last_winner_q, last_winner_d;
    logic                busy_q, busy_d;
    logic [BW-1:0]       beat_idx_q, beat_idx_d;
    logic                timeout_q, timeout_d;

    logic                arb_found;
    logic [ID_W-1:0]     arb_winner;
    logic                wd_expire;

`ifdef BUS_ARBITER_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Counter sits at zero while idle so the first GRANT cycle sees 0; the
    // release decision is taken one cycle early so the grant drops exactly
    // WATCHDOG_CYCLES cycles after grant entry.
    always_comb begin
        wd_cnt_d = (state_q == S_IDLE) ? '0 : wd_cnt_q + 1'b1;
    end
    assign wd_expire = (state_q != S_IDLE) && (wd_cnt_q >= WD_W'(WATCHDOG_CYCLES - 1));

    // Watchdog counter register
    always_ff @(posedge CLK) begin
        if (RST) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Round-robin pick: first requester scanning upward from last_winner+1
    always_comb begin
        int              c;
        logic [ID_W-1:0] c_id;
        arb_found  = 1'b0;
        arb_winner = '0;
        c          = 0;
        c_id       = '0;
        for (int k = 1; k <= NUM_CPUS; k++) begin
            c = int'(last_winner_q) + k;
            if (c >= NUM_CPUS) c = c - NUM_CPUS;
            c_id = ID_W'(c);
            if (!arb_found && req[c_id]) begin
                arb_found  = 1'b1;
                arb_winner = c_id;
            end
        end
    end

    // Transaction sequencing: IDLE -> GRANT -> XFER -> IDLE
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        beat_idx_d    = beat_idx_q;
        last_winner_d = last_winner_q;
        timeout_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d    = S_GRANT;
                    grant_d    = NUM_CPUS'(1) << arb_winner;
                    grant_id_d = arb_winner;
                    busy_d     = 1'b1;
                end
            end
            S_GRANT: begin
                // A ready controller wins over a same-cycle withdrawal.
                if (bus_ready) begin
                    state_d    = S_XFER;
                    beat_idx_d = '0;
                end else if (!req[grant_id_q]) begin
                    // Withdrawal keeps priority where it was.
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (wd_expire) begin
                    state_d       = S_IDLE;
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    timeout_d     = 1'b1;
                    last_winner_d = grant_id_q;
                end
            end
            S_XFER: begin
                if (bus_done || wd_expire) begin
                    // bus_done beats a coincident expiry; a coincident beat is dropped.
                    state_d       = S_IDLE;
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    beat_idx_d    = '0;
                    last_winner_d = grant_id_q;
                    timeout_d     = !bus_done;
                end else if (beat_valid) begin
                    beat_idx_d = (beat_idx_q == BW'(BLOCK_SIZE_WORDS - 1)) ? '0 : beat_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset puts last_winner at the top so cache 0 wins first
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            beat_idx_q    <= '0;
            last_winner_q <= ID_W'(NUM_CPUS - 1);
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            beat_idx_q    <= beat_idx_d;
            last_winner_q <= last_winner_d;
            timeout_q     <= timeout_d;
        end
    end

    // Launch pulse is combinational; suppressed while reset aborts the grant.
    assign bus_start = (state_q == S_GRANT) && bus_ready && !RST;
    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign beat_idx  = beat_idx_q;
    assign timeout   = timeout_q;

endmodule
